// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS32 core.
// Contents: opcode and funct encodings, the sequencer state type, the ALU operation type,
// and decode helpers used by the core.
package mips_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

  typedef enum logic [2:0] {AluAdd, AluSub, AluAnd, AluOr, AluSlt} alu_op_e;

  function automatic alu_op_e funct_alu_op(input logic [5:0] funct);
    alu_op_e op;
    case (funct)
      FnSub:   op = AluSub;
      FnAnd:   op = AluAnd;
      FnOr:    op = AluOr;
      FnSlt:   op = AluSlt;
      default: op = AluAdd;
    endcase
    return op;
  endfunction

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] funct);
    logic ok;
    case (op)
      OpRtype:                      ok = funct inside {FnAdd, FnSub, FnAnd, FnOr, FnSlt};
      OpAddi, OpLw, OpSw, OpBeq, OpJ: ok = 1'b1;
      default:                      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mips_mem_if.sv
// Request/valid memory port used for both instruction and data memories.
// master (core): drives req, we, addr, wdata; samples rdata, valid.
// slave (memory): the reverse. A request holds its address/data until valid is seen.
interface mips_mem_if #(
  parameter int unsigned ADDR_W = 10
) ();
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              valid;

  modport master (output req, we, addr, wdata, input rdata, valid);
  modport slave  (input req, we, addr, wdata, output rdata, valid);
endinterface

// File: rtl/mips_regfile.sv
// 32x32 register file: two asynchronous read ports, one debug read port, one synchronous
// write port. Register 0 always reads zero and ignores writes. Synchronous active-low reset
// clears every register.
module mips_regfile (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [4:0]  raddr_a_i,
  output logic [31:0] rdata_a_o,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_b_o,
  input  logic [4:0]  dbg_sel_i,
  output logic [31:0] dbg_data_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);
  logic [31:0] regs_q [32];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && waddr_i != 5'd0) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o  = (raddr_a_i == 5'd0) ? '0 : regs_q[raddr_a_i];
  assign rdata_b_o  = (raddr_b_i == 5'd0) ? '0 : regs_q[raddr_b_i];
  assign dbg_data_o = (dbg_sel_i == 5'd0) ? '0 : regs_q[dbg_sel_i];
endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS32 subset core (add/sub/and/or/slt, addi, lw, sw, beq, j).
// Ports: clock, reset_n (sync, active low); imem/dmem request/valid memory ports;
// halted (sticky stop flag); pc (byte address); dbg_sel/dbg_data (register peek).
// Sequence: FETCH -> DECODE -> EXEC -> {MEM -> WB | WB | FETCH}; HALT only left by reset.
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 10,  // must be <= 26 for the jump form below
  parameter logic [ADDR_W+1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  mips_mem_if.master        imem,
  mips_mem_if.master        dmem,
  output logic              halted,
  output logic [ADDR_W+1:0] pc,
  input  logic [4:0]        dbg_sel,
  output logic [31:0]       dbg_data
);
  localparam int unsigned PcW = ADDR_W + 2;

  state_e         state_q;
  logic [PcW-1:0] pc_q;
  logic [31:0]    ir_q, a_q, b_q, imm_q, alu_out_q, mdr_q;
  logic           imem_req_q, dmem_req_q, dmem_we_q, halted_q;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_ext, rf_a, rf_b, rf_wdata, alu_b, alu_y;
  logic [4:0]  rf_waddr;
  logic        rf_we, is_mem;
  alu_op_e     alu_op;
  logic        unused_shamt;

  assign op           = ir_q[31:26];
  assign rs           = ir_q[25:21];
  assign rt           = ir_q[20:16];
  assign rd           = ir_q[15:11];
  assign funct        = ir_q[5:0];
  assign imm_ext      = {{16{ir_q[15]}}, ir_q[15:0]};
  assign is_mem       = (op == OpLw) || (op == OpSw);
  assign unused_shamt = ^ir_q[10:6];

  always_comb begin
    alu_op = AluAdd;
    alu_b  = imm_q;
    if (op == OpRtype) begin
      alu_op = funct_alu_op(funct);
      alu_b  = b_q;
    end
    unique case (alu_op)
      AluSub:  alu_y = a_q - alu_b;
      AluAnd:  alu_y = a_q & alu_b;
      AluOr:   alu_y = a_q | alu_b;
      AluSlt:  alu_y = ($signed(a_q) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_y = a_q + alu_b;
    endcase
  end

  always_comb begin
    rf_we    = (state_q == StWb);
    rf_waddr = (op == OpRtype) ? rd : rt;
    rf_wdata = (op == OpLw) ? mdr_q : alu_out_q;
  end

  mips_regfile u_regfile (
    .clock      (clock),
    .reset_n    (reset_n),
    .raddr_a_i  (rs),
    .rdata_a_o  (rf_a),
    .raddr_b_i  (rt),
    .rdata_b_o  (rf_b),
    .dbg_sel_i  (dbg_sel),
    .dbg_data_o (dbg_data),
    .we_i       (rf_we),
    .waddr_i    (rf_waddr),
    .wdata_i    (rf_wdata)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= StFetch;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      imm_q      <= '0;
      alu_out_q  <= '0;
      mdr_q      <= '0;
      // Armed during reset; the output gate below keeps it low until reset_n releases.
      imem_req_q <= 1'b1;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (imem.valid) begin
            ir_q       <= imem.rdata;
            pc_q       <= pc_q + PcW'(4);
            imem_req_q <= 1'b0;
            state_q    <= StDecode;
          end
        end
        StDecode: begin
          a_q   <= rf_a;
          b_q   <= rf_b;
          imm_q <= imm_ext;
          if (is_legal(op, funct)) begin
            state_q <= StExec;
          end else begin
            state_q  <= StHalt;
            halted_q <= 1'b1;
          end
        end
        StExec: begin
          alu_out_q <= alu_y;
          if (op == OpBeq) begin
            // pc_q already holds PC+4.
            if (a_q == b_q) pc_q <= pc_q + {imm_q[PcW-3:0], 2'b00};
            imem_req_q <= 1'b1;
            state_q    <= StFetch;
          end else if (op == OpJ) begin
            // {PC[31:28], target, 00} truncated to PcW bits leaves only target bits.
            pc_q       <= {ir_q[PcW-3:0], 2'b00};
            imem_req_q <= 1'b1;
            state_q    <= StFetch;
          end else if (is_mem) begin
            if (alu_y[1:0] != 2'b00) begin
              state_q  <= StHalt;
              halted_q <= 1'b1;
            end else begin
              dmem_req_q <= 1'b1;
              dmem_we_q  <= (op == OpSw);
              state_q    <= StMem;
            end
          end else begin
            state_q <= StWb;
          end
        end
        StMem: begin
          if (dmem.valid) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            mdr_q      <= dmem.rdata;
            if (dmem_we_q) begin
              imem_req_q <= 1'b1;
              state_q    <= StFetch;
            end else begin
              state_q <= StWb;
            end
          end
        end
        StWb: begin
          imem_req_q <= 1'b1;
          state_q    <= StFetch;
        end
        default: begin
          state_q <= StHalt;
        end
      endcase
    end
  end

  // Gating with reset_n drops any outstanding request in the very cycle reset is applied.
  assign imem.req   = imem_req_q & reset_n;
  assign imem.we    = 1'b0;
  assign imem.addr  = pc_q[ADDR_W+1:2];
  assign imem.wdata = '0;
  assign dmem.req   = dmem_req_q & reset_n;
  assign dmem.we    = dmem_we_q;
  assign dmem.addr  = alu_out_q[ADDR_W+1:2];
  assign dmem.wdata = b_q;
  assign halted     = halted_q;
  assign pc         = pc_q;
endmodule

// File: tb/tb_mips_multicycle_core.sv
module tb_mips_multicycle_core;
  localparam logic [31:0] HaltWord = 32'hFC00_0000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  dbg_sel = '0;
  logic [31:0] dbg_data;
  logic        halted;
  logic [11:0] pc;

  mips_mem_if #(.ADDR_W(10)) imem_if ();
  mips_mem_if #(.ADDR_W(10)) dmem_if ();

  mips_multicycle_core #(.ADDR_W(10), .RESET_PC(12'h000)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .imem     (imem_if),
    .dmem     (dmem_if),
    .halted   (halted),
    .pc       (pc),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Memory models and wait-state control.
  logic [31:0] imem [1024];
  logic [31:0] dmem [1024];
  int iw = 0, dw = 0, icnt = 0, dcnt = 0, dstab_err = 0;
  int fetch_log [$];
  typedef struct {logic we; logic [9:0] addr; logic [31:0] wdata;} dtx_t;
  dtx_t dlog [$];
  dtx_t dcur;

  initial begin
    imem_if.valid = 1'b0;
    imem_if.rdata = '0;
    forever begin
      @(negedge clock);
      if (imem_if.req === 1'b1) begin
        if (icnt >= iw) begin
          imem_if.valid = 1'b1;
          imem_if.rdata = imem[imem_if.addr];
          fetch_log.push_back(int'(imem_if.addr));
        end else begin
          imem_if.valid = 1'b0;
        end
        icnt++;
      end else begin
        imem_if.valid = 1'b0;
        icnt = 0;
      end
    end
  end

  initial begin
    dmem_if.valid = 1'b0;
    dmem_if.rdata = '0;
    forever begin
      @(negedge clock);
      if (dmem_if.req === 1'b1) begin
        if (dcnt == 0) begin
          dcur.we = dmem_if.we; dcur.addr = dmem_if.addr; dcur.wdata = dmem_if.wdata;
        end else if (dmem_if.we !== dcur.we || dmem_if.addr !== dcur.addr ||
                     dmem_if.wdata !== dcur.wdata) begin
          dstab_err++;
        end
        if (dcnt >= dw) begin
          dmem_if.valid = 1'b1;
          if (dmem_if.we) dmem[dmem_if.addr] = dmem_if.wdata;
          else dmem_if.rdata = dmem[dmem_if.addr];
          dlog.push_back(dcur);
        end else begin
          dmem_if.valid = 1'b0;
        end
        dcnt++;
      end else begin
        dmem_if.valid = 1'b0;
        dcnt = 0;
      end
    end
  end

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input int rd, input int rs,
                                        input int rt);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                        input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic load_prog(input logic [31:0] p [$]);
    for (int i = 0; i < 1024; i++) imem[i] = HaltWord;
    for (int i = 0; i < p.size(); i++) imem[i] = p[i];
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    fetch_log.delete();
    dlog.delete();
    dstab_err = 0;
    reset_n = 1'b1;
  endtask

  task automatic run_until_halt(input int maxc, output int cycles);
    cycles = 0;
    do begin
      @(posedge clock); #1;
      cycles++;
    end while (halted !== 1'b1 && cycles < maxc);
  endtask

  task automatic check_reg(input int r, input logic [31:0] exp);
    dbg_sel = 5'(r);
    #1;
    check($sformatf("reg%0d", r), dbg_data, exp);
  endtask

  // ISA-level reference: executes the program word by word and totals cycle costs.
  logic [31:0] m_regs [32];
  logic [31:0] m_mem [1024];
  logic [11:0] m_pc;
  int          m_cycles;

  task automatic ref_run();
    logic [31:0] w, a, b, imm, ea, r;
    logic [5:0]  op, fn;
    bit          stop;
    m_pc = '0;
    m_cycles = 0;
    stop = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    for (int s = 0; s < 2000 && !stop; s++) begin
      w = imem[m_pc[11:2]];
      m_pc = m_pc + 12'd4;
      m_cycles += iw;
      op = w[31:26];
      fn = w[5:0];
      a = m_regs[w[25:21]];
      b = m_regs[w[20:16]];
      imm = {{16{w[15]}}, w[15:0]};
      r = '0;
      if (op == 6'h00 && fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) begin
        case (fn)
          6'h20:   r = a + b;
          6'h22:   r = a - b;
          6'h24:   r = a & b;
          6'h25:   r = a | b;
          default: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
        if (w[15:11] != 0) m_regs[w[15:11]] = r;
        m_cycles += 4;
      end else if (op == 6'h08) begin
        if (w[20:16] != 0) m_regs[w[20:16]] = a + imm;
        m_cycles += 4;
      end else if (op == 6'h23 || op == 6'h2B) begin
        ea = a + imm;
        if (ea[1:0] != 0) begin
          m_cycles += 3;
          stop = 1;
        end else if (op == 6'h23) begin
          if (w[20:16] != 0) m_regs[w[20:16]] = m_mem[ea[11:2]];
          m_cycles += 5 + dw;
        end else begin
          m_mem[ea[11:2]] = b;
          m_cycles += 4 + dw;
        end
      end else if (op == 6'h04) begin
        if (a == b) m_pc = m_pc + 12'(imm * 4);
        m_cycles += 3;
      end else if (op == 6'h02) begin
        m_pc = {w[9:0], 2'b00};
        m_cycles += 3;
      end else begin
        m_cycles += 2;
        stop = 1;
      end
    end
  endtask

  typedef struct {logic [4:0] sel; logic [31:0] exp;} rvec_t;

  initial begin
    rvec_t       rtab [$];
    logic [31:0] prog [$];
    logic [5:0]  fn_tab [5];
    int          cyc;
    logic [11:0] pc_hold;

    rtab = '{'{5'd16, 32'h14}, '{5'd17, 32'h5A}, '{5'd18, 32'h6E}, '{5'd19, 32'hFFFF_FFBA},
             '{5'd20, 32'h10}, '{5'd21, 32'h5E}, '{5'd22, 32'h0}, '{5'd24, 32'h1},
             '{5'd25, 32'h1}, '{5'd0, 32'h0}, '{5'd23, 32'h6E}};
    fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    // Arithmetic, $0 discard, store/load with a slow data port.
    prog = '{enc_i(6'h08, 0, 16, 'h14), enc_i(6'h08, 0, 17, 'h5A),
             enc_r(6'h20, 18, 16, 17), enc_r(6'h22, 19, 16, 17), enc_r(6'h24, 20, 16, 17),
             enc_r(6'h25, 21, 16, 17), enc_r(6'h2A, 22, 17, 16), enc_r(6'h2A, 24, 16, 17),
             enc_r(6'h2A, 25, 19, 16), enc_r(6'h20, 0, 16, 17),
             enc_i(6'h2B, 0, 18, 8), enc_i(6'h23, 0, 23, 8)};
    load_prog(prog);
    iw = 0;
    dw = 3;
    reset_n = 1'b0;
    @(posedge clock); #1;
    check("reset imem_req", 32'(imem_if.req), 32'd0);
    check("reset dmem_req", 32'(dmem_if.req), 32'd0);
    check("reset halted", 32'(halted), 32'd0);
    check("reset pc", 32'(pc), 32'd0);
    check_reg(5, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    #1;
    check("first imem_req", 32'(imem_if.req), 32'd1);
    check("first imem_addr", 32'(imem_if.addr), 32'd0);
    run_until_halt(500, cyc);
    check("prog1 halted", 32'(halted), 32'd1);
    check("prog1 cycles", 32'(cyc), 32'd57);
    check("prog1 pc", 32'(pc), 32'd52);
    for (int i = 0; i < rtab.size(); i++) check_reg(int'(rtab[i].sel), rtab[i].exp);
    check("dmem stable while waiting", 32'(dstab_err), 32'd0);
    check("dmem tx count", 32'(dlog.size()), 32'd2);
    if (dlog.size() >= 2) begin
      check("sw we", 32'(dlog[0].we), 32'd1);
      check("sw addr", 32'(dlog[0].addr), 32'd2);
      check("sw wdata", dlog[0].wdata, 32'h6E);
      check("lw we", 32'(dlog[1].we), 32'd0);
      check("lw addr", 32'(dlog[1].addr), 32'd2);
    end

    // Branches: untaken goes to PC+4, taken with imm=-2 lands at PC+4-8.
    prog = '{enc_i(6'h08, 0, 1, 5), enc_i(6'h04, 1, 0, 1), enc_i(6'h04, 1, 1, -2)};
    load_prog(prog);
    iw = 1;
    dw = 0;
    do_reset();
    for (int c = 0; c < 200 && fetch_log.size() < 6; c++) @(posedge clock);
    #1;
    check("branch fetch count", 32'(fetch_log.size() >= 6), 32'd1);
    begin
      int exp_f [6] = '{0, 1, 2, 1, 2, 1};
      for (int i = 0; i < 6 && i < fetch_log.size(); i++)
        check($sformatf("branch fetch%0d", i), 32'(fetch_log[i]), 32'(exp_f[i]));
    end

    // Illegal opcode 0x3F.
    prog = '{HaltWord};
    load_prog(prog);
    iw = 0;
    do_reset();
    run_until_halt(50, cyc);
    check("illegal halted", 32'(halted), 32'd1);
    check("illegal cycles", 32'(cyc), 32'd2);
    check("illegal pc", 32'(pc), 32'd4);

    // Misaligned load halts in EXEC and freezes everything.
    prog = '{enc_i(6'h08, 0, 1, 6), enc_i(6'h23, 1, 2, 0)};
    load_prog(prog);
    do_reset();
    run_until_halt(50, cyc);
    check("misaligned halted", 32'(halted), 32'd1);
    check("misaligned cycles", 32'(cyc), 32'd7);
    pc_hold = pc;
    repeat (5) @(posedge clock);
    #1;
    check("halt pc frozen", 32'(pc), 32'd8);
    check("halt pc unchanged", 32'(pc), 32'(pc_hold));
    check("halt imem_req", 32'(imem_if.req), 32'd0);
    check("halt dmem_req", 32'(dmem_if.req), 32'd0);
    check("halt still halted", 32'(halted), 32'd1);
    check_reg(2, 32'd0);
    check_reg(1, 32'd6);

    // Reset while a fetch is waiting.
    prog = '{enc_i(6'h08, 0, 1, 6), enc_i(6'h08, 0, 2, 7)};
    load_prog(prog);
    iw = 0;
    do_reset();
    repeat (4) @(posedge clock);
    #1;
    iw = 50;
    repeat (3) @(posedge clock);
    #1;
    check("waiting imem_req", 32'(imem_if.req), 32'd1);
    check_reg(1, 32'd6);
    reset_n = 1'b0;
    #1;
    check("req drops in reset", 32'(imem_if.req), 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    iw = 0;
    #1;
    check("post-reset pc", 32'(pc), 32'd0);
    check("post-reset imem_req", 32'(imem_if.req), 32'd1);
    check("post-reset imem_addr", 32'(imem_if.addr), 32'd0);
    check("post-reset halted", 32'(halted), 32'd0);
    check_reg(1, 32'd0);
    run_until_halt(100, cyc);
    check("rerun cycles", 32'(cyc), 32'd10);
    check_reg(2, 32'd7);

    // Random programs against the reference model.
    for (int run = 0; run < 6; run++) begin
      prog.delete();
      for (int i = 0; i < 24; i++) begin
        int k = $urandom_range(0, 9);
        int rs = $urandom_range(0, 7);
        int rt = $urandom_range(0, 7);
        int rd = $urandom_range(0, 7);
        if (k < 5) prog.push_back(enc_r(fn_tab[k], rd, rs, rt));
        else if (k == 5) prog.push_back(enc_i(6'h08, rs, rt, $urandom_range(0, 65535)));
        else if (k == 6) prog.push_back(enc_i(6'h23, 0, rt, 4 * $urandom_range(0, 15)));
        else if (k == 7) prog.push_back(enc_i(6'h2B, 0, rt, 4 * $urandom_range(0, 15)));
        else if (k == 8) prog.push_back(enc_i(6'h04, rs, rt, $urandom_range(0, 2)));
        else prog.push_back({6'h02, 26'(i + 1 + $urandom_range(0, 2))});
      end
      load_prog(prog);
      for (int i = 0; i < 1024; i++) begin
        dmem[i] = $urandom();
        m_mem[i] = dmem[i];
      end
      iw = $urandom_range(0, 2);
      dw = $urandom_range(0, 2);
      ref_run();
      do_reset();
      run_until_halt(3000, cyc);
      check($sformatf("rand%0d halted", run), 32'(halted), 32'd1);
      check($sformatf("rand%0d cycles", run), 32'(cyc), 32'(m_cycles));
      check($sformatf("rand%0d pc", run), 32'(pc), 32'(m_pc));
      for (int r = 0; r < 32; r++) check_reg(r, m_regs[r]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_core.md
# mips_multicycle_core

Multi-cycle MIPS32 integer core executing a subset of R-type and I-type instructions over a finite-state sequencer, with external instruction and data memories on request/valid handshakes. It replaces the single-always-block R-type datapath as the CPU instance in the processor top level. Memories, clock generation and program loading sit outside the block.

## Interface
- ADDR_W, 10: word-address width of both memory ports; byte space is 2^(ADDR_W+2).
- RESET_PC, 0: byte address loaded into PC on reset; must be word-aligned.
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  ADDR_W  word address, PC[ADDR_W+1:2].
- imem_rdata  in  32  instruction word, sampled when imem_valid=1.
- imem_valid  in  1  fetch completes this cycle.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1=store, 0=load; stable while dmem_req=1.
- dmem_addr  out  ADDR_W  word address, ALUOut[ADDR_W+1:2].
- dmem_wdata  out  32  store data.
- dmem_rdata  in  32  load data, sampled when dmem_valid=1.
- dmem_valid  in  1  data access completes this cycle.
- halted  out  1  sticky; core stopped.
- pc  out  ADDR_W+2  current PC (byte address).
- dbg_sel  in  5  register file read select.
- dbg_data  out  32  combinational read of Regs[dbg_sel].

## Operation
- Instructions: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (op 0); addi 0x08, lw 0x23, sw 0x2B, beq 0x04, j 0x02. Any other op/funct -> HALT.
- Arithmetic 32-bit, wraps, no overflow trap. slt signed compare, result 0/1. Immediates sign-extended to 32 bits.
- Register $0 reads 0; writes to it discarded.
- States: FETCH -> DECODE -> EXEC -> {MEM -> WB | WB | FETCH} ; HALT absorbing.
  - FETCH: imem_req=1; on imem_valid latch IR, PC<=PC+4, go DECODE.
  - DECODE: latch A=Regs[rs], B=Regs[rt], sign-extended imm; illegal encoding -> HALT.
  - EXEC: R-type ALUOut<=A op B; addi/lw/sw ALUOut<=A+imm; beq: if A==B PC<=PC+(imm<<2), go FETCH; j: PC<={PC[31:28],IR[25:0],2'b00} truncated to ADDR_W+2 bits, go FETCH. lw/sw with ALUOut[1:0]!=0 -> HALT.
  - MEM: dmem_req=1; on dmem_valid: sw -> FETCH; lw latch MDR, go WB.
  - WB: R-type Regs[rd]<=ALUOut; addi Regs[rt]<=ALUOut; lw Regs[rt]<=MDR. Go FETCH.
- Handshake: req asserted with address/data stable until valid sampled high in the same cycle; req drops the following cycle. valid while req=0 is ignored. No limit on wait cycles.

## Timing
- Reset values: PC=RESET_PC, all Regs=0, IR=0, state=FETCH, imem_req=0 in the reset cycle then 1 from first cycle out of reset, dmem_req=0, dmem_we=0, halted=0.
- Zero-wait memory cycle counts (FETCH through last state): beq/j 3, sw 4, R-type/addi 4, lw 5. Each wait cycle on a port adds one.
- Register write visible to DECODE of the next instruction (no forwarding needed; strictly sequential).
- reset_n low in any state, including mid-handshake: next edge reinitialises; outstanding req drops; memory must tolerate abandoned requests.
- HALT: all req=0, PC/Regs frozen; exits only via reset.
- PC wraps modulo 2^(ADDR_W+2).

## Structure
- Package mips_pkg: opcode and funct localparams, state enum type, ALU-op enum.
- Sub-module mips_regfile: 32x32, two async read ports plus dbg port, one sync write port, $0 hardwired; reset clears.
- ALU, decode and sequencer stay in the top module.

## Test plan
- addi $16,$0,0x14; addi $17,$0,0x5A; add $18,$16,$17; sub $19; and $20; or $21; slt $22,$17,$16 -> dbg reads $18=0x6E, $19=0xFFFFFFBA, $20=0x10, $21=0x5E, $22=0.
- sw $18,8($0) then lw $23,8($0), dmem_valid delayed 3 cycles -> dmem_we/addr=2/wdata=0x6E held stable throughout; $23=0x6E; lw takes 5+3 cycles.
- beq equal with imm=-2 and beq unequal -> taken lands PC+4-8, untaken PC+4; add $0,$16,$17 -> $0 stays 0.
- reset_n low for one cycle while imem_req waiting -> next cycle PC=RESET_PC, regs 0, imem_req re-asserts at RESET_PC.
- Opcode 0x3F, and lw at address 0x6 -> halted=1, all req low, pc frozen until reset.
